// File: rtl/ysyx_25040109_lsu.sv
// ysyx_25040109_lsu -- load/store unit between EXU and the dmem channel.
//
// One request in flight at a time. The request is latched on the req handshake.
// The dmem access happens in a single LOAD or STORE cycle. The result is then
// held in RESP until the consumer takes it.
//
// Optional feature macro: LSU_MISALIGN_EXC_EN
//   defined   : misaligned half/word requests and size=11 are rejected. They go
//               IDLE->RESP with resp_err=1 and make no dmem access.
//   undefined : no checking. The low address bits are forced to size alignment
//               and resp_err is tied to 0.
//
// Ports
//   clk, rst           clock; synchronous active-low reset
//   req_*              EXU request channel (valid/ready, wen, addr, wdata, size, unsigned)
//   resp_*             response channel (valid/ready, rdata, err)
//   dmem_raddr/ren     word-aligned read; dmem_rdata is returned in the same cycle
//   dmem_rdata         read word
//   dmem_waddr/wdata   store byte address and raw store data
//   dmem_wlen/wen      store length (001/010/100) and write strobe
module ysyx_25040109_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] dmem_raddr,
  output logic            dmem_ren,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] dmem_waddr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [2:0]      dmem_wlen,
  output logic            dmem_wen
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, RESP} state_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [1:0]      size;
    logic            uns;
  } lsu_req_t;

  state_t          state, state_nx;
  lsu_req_t        req_q;
  logic            accept;
  logic [XLEN-1:0] eff_addr;
  logic [XLEN-1:0] load_ext;

  // Extract the addressed lane from a read word and extend it.
  function automatic logic [XLEN-1:0] lane_ext(input logic [XLEN-1:0] word,
                                               input logic [1:0] off,
                                               input logic [1:0] size,
                                               input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   lane_ext = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   lane_ext = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: lane_ext = word;  // word and reserved size
    endcase
  endfunction

`ifdef LSU_MISALIGN_EXC_EN
  logic mis_in;
  logic resp_err_q;

  // Misalignment is judged on the incoming request so a bad access never
  // reaches dmem.
  always_comb begin
    case (req_size)
      2'b00:   mis_in = 1'b0;
      2'b01:   mis_in = req_addr[0];
      2'b10:   mis_in = |req_addr[1:0];
      default: mis_in = 1'b1;
    endcase
  end

  assign eff_addr = req_q.addr;
  assign resp_err = resp_err_q;
`else
  // Without checking, silently align to the access size.
  always_comb begin
    case (req_q.size)
      2'b00:   eff_addr = req_q.addr;
      2'b01:   eff_addr = {req_q.addr[XLEN-1:1], 1'b0};
      default: eff_addr = {req_q.addr[XLEN-1:2], 2'b00};
    endcase
  end

  assign resp_err = 1'b0;
`endif

  assign accept   = req_valid && req_ready;
  assign load_ext = lane_ext(dmem_rdata, eff_addr[1:0], req_q.size, req_q.uns);

  // dmem address/data buses follow the latched request; only the strobes are qualified.
  assign dmem_raddr = {req_q.addr[XLEN-1:2], 2'b00};
  assign dmem_waddr = eff_addr;
  assign dmem_wdata = req_q.wdata;

  // Next state and state-decoded outputs. Every strobe is gated by rst so a
  // reset arriving mid-transaction suppresses the access at that very edge.
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    dmem_ren   = 1'b0;
    dmem_wen   = 1'b0;
    dmem_wlen  = 3'b000;
    case (state)
      IDLE: begin
        req_ready = rst;
        if (req_valid) begin
          state_nx = req_wen ? STORE : LOAD;
`ifdef LSU_MISALIGN_EXC_EN
          if (mis_in) state_nx = RESP;
`endif
        end
      end
      LOAD: begin
        dmem_ren = rst;
        state_nx = RESP;
      end
      STORE: begin
        dmem_wen = rst;
        if (rst) begin
          case (req_q.size)
            2'b00:   dmem_wlen = 3'b001;
            2'b01:   dmem_wlen = 3'b010;
            default: dmem_wlen = 3'b100;
          endcase
        end
        state_nx = RESP;
      end
      RESP: begin
        resp_valid = rst;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // The request latch needs no reset: it is only read after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_q.addr  <= req_addr;
      req_q.wdata <= req_wdata;
      req_q.size  <= req_size;
      req_q.uns   <= req_unsigned;
    end
  end

  // Response registers only change on accept, LOAD or STORE, so they hold
  // steady for the whole of RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      resp_rdata <= '0;
`ifdef LSU_MISALIGN_EXC_EN
      resp_err_q <= 1'b0;
`endif
    end else begin
`ifdef LSU_MISALIGN_EXC_EN
      if (accept) begin
        resp_err_q <= mis_in;
        if (mis_in) resp_rdata <= '0;
      end
`endif
      if (state == LOAD)  resp_rdata <= load_ext;
      if (state == STORE) resp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
// Scoreboard bench for ysyx_25040109_lsu. Stimulus pushes expected responses
// and dmem accesses into queues. Monitors on the falling edge pop and compare
// whenever the DUT shows a response handshake or a dmem strobe.
module tb_ysyx_25040109_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] dmem_raddr;
  logic        dmem_ren;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] dmem_waddr;
  logic [31:0] dmem_wdata;
  logic [2:0]  dmem_wlen;
  logic        dmem_wen;

  ysyx_25040109_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dmem_raddr(dmem_raddr), .dmem_ren(dmem_ren), .dmem_rdata(dmem_rdata),
    .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
    .dmem_wlen(dmem_wlen), .dmem_wen(dmem_wen)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic err; } resp_t;
  typedef struct { logic wen; logic [31:0] addr; logic [31:0] wdata; logic [2:0] wlen; } acc_t;

  resp_t sb_resp[$];
  acc_t  sb_acc[$];
  int    checks = 0;
  int    errors = 0;
  int    wr_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) if (dmem_wen) wr_count++;

  // Response monitor
  always @(negedge clk) begin
    if (rst && resp_valid && resp_ready) begin
      if (sb_resp.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_unexpected: got rdata %h with nothing expected", resp_rdata);
      end else begin
        resp_t e;
        e = sb_resp.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
      end
    end
  end

  // dmem access monitor
  always @(negedge clk) begin
    if (dmem_ren || dmem_wen) begin
      if (sb_acc.size() == 0) begin
        checks++; errors++;
        $display("FAIL dmem_unexpected: got ren=%0b wen=%0b with nothing expected", dmem_ren, dmem_wen);
      end else begin
        acc_t a;
        a = sb_acc.pop_front();
        chk("dmem_wen", {31'b0, dmem_wen}, {31'b0, a.wen});
        chk("dmem_ren", {31'b0, dmem_ren}, {31'b0, !a.wen});
        if (a.wen) begin
          chk("dmem_waddr", dmem_waddr, a.addr);
          chk("dmem_wdata", dmem_wdata, a.wdata);
          chk("dmem_wlen", {29'b0, dmem_wlen}, {29'b0, a.wlen});
        end else begin
          chk("dmem_raddr", dmem_raddr, a.addr);
        end
      end
    end
  end

  // One transaction. exp_acc=0 means no dmem access is expected (error path).
  // hold>0 withholds resp_ready for that many cycles and pulses a stray request.
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input logic [31:0] word,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                       input logic exp_acc, input logic [31:0] exp_daddr,
                       input logic [2:0] exp_wlen, input int hold);
    resp_t r;
    acc_t  a;
    int    lat;
    @(posedge clk); #1;
    dmem_rdata = word;
    req_wen = wen; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
    resp_ready = (hold == 0);
    req_valid = 1'b1;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    r.rdata = exp_rd; r.err = exp_err;
    sb_resp.push_back(r);
    if (exp_acc) begin
      a.wen = wen; a.addr = exp_daddr; a.wdata = wdata; a.wlen = exp_wlen;
      sb_acc.push_back(a);
    end
    @(posedge clk); #1;
    // Scramble the inputs to show the DUT works from its latched copy.
    req_valid = 1'b0; req_addr = 32'h0BAD_F00D; req_wdata = 32'h0; req_size = 2'b11;
    req_unsigned = ~uns;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      if (resp_valid) begin lat = i; break; end
      @(posedge clk); #1;
    end
    chk("latency", lat, exp_lat);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", {31'b0, resp_valid}, 32'd1);
        chk("hold_rdata", resp_rdata, exp_rd);
        chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
        if (i == 1) begin
          req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0040;
          req_wdata = 32'hFFFF_FFFF; req_size = 2'b10;
        end else begin
          req_valid = 1'b0;
        end
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
    end
    for (int i = 0; i < 20 && sb_resp.size() != 0; i++) @(negedge clk);
    chk("resp_drained", sb_resp.size(), 0);
    chk("acc_drained", sb_acc.size(), 0);
    @(posedge clk); #1;
  endtask

  int wc0;

  initial begin
    // Reset
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_ren", {31'b0, dmem_ren}, 32'd0);
    chk("rst_wen", {31'b0, dmem_wen}, 32'd0);
    chk("rst_wlen", {29'b0, dmem_wlen}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("post_rst_rdata", resp_rdata, 32'd0);
    chk("post_rst_err", {31'b0, resp_err}, 32'd0);

    //     wen  addr          wdata         sz  uns word          exp_rd        err lat acc daddr         wlen  hold
    issue(1'b0, 32'h8000_0004, 32'h0,        2'b10, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 2, 1'b1, 32'h8000_0004, 3'b000, 0);
    issue(1'b0, 32'h8000_0003, 32'h0,        2'b00, 1'b0, 32'h80AA_5512, 32'hFFFF_FF80, 1'b0, 2, 1'b1, 32'h8000_0000, 3'b000, 0);
    issue(1'b0, 32'h8000_0003, 32'h0,        2'b00, 1'b1, 32'h80AA_5512, 32'h0000_0080, 1'b0, 2, 1'b1, 32'h8000_0000, 3'b000, 0);
    issue(1'b0, 32'h8000_0001, 32'h0,        2'b00, 1'b0, 32'h80AA_5512, 32'h0000_0055, 1'b0, 2, 1'b1, 32'h8000_0000, 3'b000, 0);
    issue(1'b0, 32'h8000_0002, 32'h0,        2'b00, 1'b0, 32'h80AA_5512, 32'hFFFF_FFAA, 1'b0, 2, 1'b1, 32'h8000_0000, 3'b000, 0);
    issue(1'b0, 32'h8000_0002, 32'h0,        2'b01, 1'b0, 32'h80AA_5512, 32'hFFFF_80AA, 1'b0, 2, 1'b1, 32'h8000_0000, 3'b000, 0);
    issue(1'b0, 32'h8000_0002, 32'h0,        2'b01, 1'b1, 32'h80AA_5512, 32'h0000_80AA, 1'b0, 2, 1'b1, 32'h8000_0000, 3'b000, 0);
    issue(1'b0, 32'h8000_0000, 32'h0,        2'b01, 1'b0, 32'h80AA_5512, 32'h0000_5512, 1'b0, 2, 1'b1, 32'h8000_0000, 3'b000, 0);
    issue(1'b1, 32'h8000_0002, 32'h1234_ABCD, 2'b01, 1'b0, 32'h0,       32'h0,         1'b0, 2, 1'b1, 32'h8000_0002, 3'b010, 0);
    issue(1'b1, 32'h8000_0001, 32'h0000_00A5, 2'b00, 1'b0, 32'h0,       32'h0,         1'b0, 2, 1'b1, 32'h8000_0001, 3'b001, 0);
    issue(1'b1, 32'h8000_0008, 32'hCAFE_BABE, 2'b10, 1'b0, 32'h0,       32'h0,         1'b0, 2, 1'b1, 32'h8000_0008, 3'b100, 0);
    // Backpressure: resp_ready low for 5 cycles, with a stray request that must be dropped
    issue(1'b0, 32'h8000_0010, 32'h0,        2'b10, 1'b0, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 2, 1'b1, 32'h8000_0010, 3'b000, 5);

`ifdef LSU_MISALIGN_EXC_EN
    issue(1'b0, 32'h8000_0006, 32'h0,        2'b10, 1'b0, 32'hCAFE_F00D, 32'h0,         1'b1, 1, 1'b0, 32'h0,         3'b000, 0);
    issue(1'b0, 32'h8000_0001, 32'h0,        2'b01, 1'b0, 32'h80AA_5512, 32'h0,         1'b1, 1, 1'b0, 32'h0,         3'b000, 0);
    issue(1'b0, 32'h8000_0000, 32'h0,        2'b11, 1'b0, 32'h1122_3344, 32'h0,         1'b1, 1, 1'b0, 32'h0,         3'b000, 0);
    issue(1'b1, 32'h8000_0006, 32'h5555_AAAA, 2'b10, 1'b0, 32'h0,       32'h0,         1'b1, 1, 1'b0, 32'h0,         3'b000, 0);
    // A good access after an error must clear resp_err
    issue(1'b0, 32'h8000_0004, 32'h0,        2'b10, 1'b0, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 2, 1'b1, 32'h8000_0004, 3'b000, 0);
`else
    issue(1'b0, 32'h8000_0006, 32'h0,        2'b10, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 2, 1'b1, 32'h8000_0004, 3'b000, 0);
    issue(1'b0, 32'h8000_0001, 32'h0,        2'b01, 1'b0, 32'h80AA_5512, 32'h0000_5512, 1'b0, 2, 1'b1, 32'h8000_0000, 3'b000, 0);
    issue(1'b0, 32'h8000_0003, 32'h0,        2'b11, 1'b0, 32'h1122_3344, 32'h1122_3344, 1'b0, 2, 1'b1, 32'h8000_0000, 3'b000, 0);
    issue(1'b1, 32'h8000_0006, 32'h5555_AAAA, 2'b10, 1'b0, 32'h0,       32'h0,         1'b0, 2, 1'b1, 32'h8000_0004, 3'b100, 0);
    issue(1'b1, 32'h8000_0003, 32'h0000_7777, 2'b01, 1'b0, 32'h0,       32'h0,         1'b0, 2, 1'b1, 32'h8000_0002, 3'b010, 0);
`endif

    // Reset asserted while in STORE: no write, back to IDLE with no response
    @(posedge clk); #1;
    req_wen = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'h0000_0055; req_size = 2'b10;
    req_valid = 1'b1;
    chk("rst_store_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    wc0 = wr_count;
    @(negedge clk);
    chk("rst_store_wen", {31'b0, dmem_wen}, 32'd0);
    chk("rst_store_wlen", {29'b0, dmem_wlen}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_store_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_store_idle", {31'b0, req_ready}, 32'd1);
    chk("rst_store_no_write", wr_count, wc0);
    repeat (3) @(negedge clk);
    chk("rst_store_still_quiet", {31'b0, resp_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
